// File: rtl/sb_drain_ctrl_pkg.sv
// sb_drain_ctrl_pkg: shared sizes, parameter defaults and FSM encoding for the store-buffer drain controller
package sb_drain_ctrl_pkg;
  localparam int DEF_NLINES = 4;
  localparam int DEF_MAX_WAIT = 8;
  localparam int DEF_LOW_WATER = 1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } state_t;
endpackage

// File: rtl/sb_drain_ctrl_age.sv
// sb_age_counter: saturating count of pipeline-held cycles while the store buffer has pending entries
module sb_age_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] age;
  // clear wins over increment; hold once MAX is reached
  always_ff @(posedge clk or posedge reset)
    if (reset) age <= '0;
    else age <= clr ? '0 : (inc && !sat) ? age + W'(1) : age;
  assign sat = age == W'(MAX);
endmodule

// File: rtl/sb_drain_ctrl.sv
// sb_drain_ctrl: arbitrates the data-cache port between the MEM stage and store-buffer drain writes
module sb_drain_ctrl
  import sb_drain_ctrl_pkg::*;
#(
  parameter int SB_NLINES = DEF_NLINES,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int LOW_WATER = DEF_LOW_WATER
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipe_mem_req,
  input  logic                             pipe_is_store,
  input  logic [$clog2(SB_NLINES+1)-1:0]   sb_count,
  input  logic [ADDR_W-1:0]                sb_head_addr,
  input  logic [DATA_W-1:0]                sb_head_data,
  input  logic                             cache_ready,
  output logic                             pipe_grant,
  output logic                             pipe_stall,
  output logic                             cache_wr_en,
  output logic [ADDR_W-1:0]                cache_wr_addr,
  output logic [DATA_W-1:0]                cache_wr_data,
  output logic                             sb_pop,
  output logic [1:0]                       state
);
  localparam int CW = $clog2(SB_NLINES + 1);
  state_t state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic fwd, idle, full, nz, sat, done, more, force_go, drain_go;
  assign idle = state_q == IDLE;
  assign full = sb_count == CW'(SB_NLINES);
  assign nz = sb_count != '0;
  assign force_go = idle && (full || (sat && nz));
  assign drain_go = idle && !force_go && !pipe_mem_req && nz;
  assign pipe_grant = !reset && idle && pipe_mem_req && !force_go && !(pipe_is_store && full);
  assign pipe_stall = !reset && pipe_mem_req && !pipe_grant;
  assign done = cache_wr_en && cache_ready;
  assign sb_pop = done;
  assign more = (sb_count - CW'(1)) > CW'(LOW_WATER);
  // after a back-to-back reload the popped SB already shows its next head, so pass it through until captured
  assign cache_wr_addr = fwd ? sb_head_addr : addr_q;
  assign cache_wr_data = fwd ? sb_head_data : data_q;
  assign state = state_q;
  sb_age_counter #(.MAX(MAX_WAIT)) u_age (
    .clk  (clk),
    .reset(reset),
    .inc  (idle && pipe_grant && nz),
    .clr  (done || !nz),
    .sat  (sat)
  );
  // drain FSM: launch, hold under back-pressure, reload in FORCE above the low-water mark
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cache_wr_en <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      fwd <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (force_go || drain_go) begin
            state_q <= force_go ? FORCE : DRAIN;
            cache_wr_en <= 1'b1;
            addr_q <= sb_head_addr;
            data_q <= sb_head_data;
            fwd <= 1'b0;
          end
        DRAIN, FORCE:
          if (done && state_q == FORCE && more) fwd <= 1'b1;
          else if (done) begin
            state_q <= IDLE;
            cache_wr_en <= 1'b0;
            fwd <= 1'b0;
          end else if (fwd) begin
            addr_q <= sb_head_addr;
            data_q <= sb_head_data;
            fwd <= 1'b0;
          end
        default: begin
          state_q <= IDLE;
          cache_wr_en <= 1'b0;
          fwd <= 1'b0;
        end
      endcase
    end
endmodule
